// File: rtl/hue_prep_pipe.sv
// Two-stage hue front end: normalise packed RGB, pick sector, emit dividend/divisor/value.
// Optional grey handling is enabled by defining HUE_ACHROMA_EN.
module hue_prep_pipe #(
    parameter int R_W = 5,
    parameter int G_W = 6,
    parameter int B_W = 5,
    parameter int W   = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic [R_W+G_W+B_W-1:0] i_data,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic [W:0]             o_dividend,
    output logic [W:0]             o_divisor,
    output logic [W-1:0]           o_value,
    output logic [1:0]             o_function,
    output logic                   o_valid,
    input  logic                   i_ready
);

    localparam int D_W = R_W + G_W + B_W;
    localparam int C_W   [3] = '{R_W, G_W, B_W};
    localparam int C_LSB [3] = '{0, R_W, R_W + G_W};

    logic [W-1:0] comp_n [3];

    // Each field is masked out of the packed word and left-aligned into W bits.
    for (genvar gi = 0; gi < 3; gi++) begin : g_norm
        logic [D_W-1:0] field;
        assign field       = (i_data >> C_LSB[gi]) & ({D_W{1'b1}} >> (D_W - C_W[gi]));
        assign comp_n[gi]  = W'(field) << (W - C_W[gi]);
    end

    logic         adv_a, adv_b;
    logic         a_valid_q, b_valid_q;
    logic [W-1:0] a_r_q, a_g_q, a_b_q, a_max_q, a_min_q;
    logic [1:0]   a_sec_q;
    logic [W-1:0] max_d, min_d;
    logic [1:0]   sec_d;
    logic [W:0]   dividend_d, divisor_d, dividend_q, divisor_q;
    logic [W-1:0] value_q;
    logic [1:0]   function_q;

    assign adv_b   = !b_valid_q || i_ready;
    assign adv_a   = !a_valid_q || adv_b;
    assign o_ready = adv_a;

    always_comb begin
        max_d = comp_n[2];
        sec_d = 2'd3;
        if (comp_n[0] >= comp_n[1] && comp_n[0] >= comp_n[2]) begin
            max_d = comp_n[0];
            sec_d = 2'd1;
        end else if (comp_n[1] >= comp_n[2]) begin
            max_d = comp_n[1];
            sec_d = 2'd2;
        end
        min_d = comp_n[2];
        if (comp_n[0] <= comp_n[1] && comp_n[0] <= comp_n[2]) begin
            min_d = comp_n[0];
        end else if (comp_n[1] <= comp_n[2]) begin
            min_d = comp_n[1];
        end
`ifdef HUE_ACHROMA_EN
        if (max_d == min_d) begin
            sec_d = 2'd0;
        end
`endif
    end

    always_comb begin
        dividend_d = '0;
        case (a_sec_q)
            2'd1:    dividend_d = {1'b0, a_g_q} - {1'b0, a_b_q};
            2'd2:    dividend_d = {1'b0, a_b_q} - {1'b0, a_r_q};
            2'd3:    dividend_d = {1'b0, a_r_q} - {1'b0, a_g_q};
            default: dividend_d = '0;
        endcase
        divisor_d = {1'b0, a_max_q} - {1'b0, a_min_q};
`ifdef HUE_ACHROMA_EN
        // Grey pixels get a unit divisor so the divider never sees zero.
        if (a_sec_q == 2'd0) begin
            divisor_d = (W+1)'(1);
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            a_valid_q  <= 1'b0;
            a_r_q      <= '0;
            a_g_q      <= '0;
            a_b_q      <= '0;
            a_max_q    <= '0;
            a_min_q    <= '0;
            a_sec_q    <= '0;
            b_valid_q  <= 1'b0;
            dividend_q <= '0;
            divisor_q  <= '0;
            value_q    <= '0;
            function_q <= '0;
        end else begin
            if (adv_a) begin
                a_valid_q <= i_valid;
                if (i_valid) begin
                    a_r_q   <= comp_n[0];
                    a_g_q   <= comp_n[1];
                    a_b_q   <= comp_n[2];
                    a_max_q <= max_d;
                    a_min_q <= min_d;
                    a_sec_q <= sec_d;
                end
            end
            if (adv_b) begin
                b_valid_q <= a_valid_q;
                if (a_valid_q) begin
                    dividend_q <= dividend_d;
                    divisor_q  <= divisor_d;
                    value_q    <= a_max_q;
                    function_q <= a_sec_q;
                end
            end
        end
    end

    assign o_valid    = b_valid_q;
    assign o_dividend = dividend_q;
    assign o_divisor  = divisor_q;
    assign o_value    = value_q;
    assign o_function = function_q;

endmodule

// File: tb/tb_hue_prep_pipe.sv
// Bench for hue_prep_pipe: directed test-plan cases plus randomized handshake traffic
// checked against a queue-based reference model.
module tb_hue_prep_pipe;

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b0;
    logic [15:0] i_data = '0;
    logic        o_ready, o_valid;
    logic [8:0]  o_dividend, o_divisor;
    logic [7:0]  o_value;
    logic [1:0]  o_function;

    hue_prep_pipe #(.R_W(5), .G_W(6), .B_W(5), .W(8)) dut (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .o_dividend (o_dividend),
        .o_divisor  (o_divisor),
        .o_value    (o_value),
        .o_function (o_function),
        .o_valid    (o_valid),
        .i_ready    (i_ready)
    );

    always #5 i_clk = ~i_clk;

    wire [27:0] bundle = {o_function, o_dividend, o_divisor, o_value};

    int checks_cnt = 0;
    int errors_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Reference: plain integer arithmetic on the unpacked pixel.
    function automatic logic [27:0] model(input logic [15:0] p);
        int r, g, b, mx, mn, fn, dv, ds;
        r  = int'(p & 16'h001F) * 8;
        g  = int'((p >> 5) & 16'h003F) * 4;
        b  = int'((p >> 11) & 16'h001F) * 8;
        mx = r; if (g > mx) mx = g; if (b > mx) mx = b;
        mn = r; if (g < mn) mn = g; if (b < mn) mn = b;
        if (r >= g && r >= b) begin fn = 1; dv = g - b; end
        else if (g >= b)      begin fn = 2; dv = b - r; end
        else                  begin fn = 3; dv = r - g; end
        ds = mx - mn;
`ifdef HUE_ACHROMA_EN
        if (mx == mn) begin fn = 0; dv = 0; ds = 1; end
`endif
        return {fn[1:0], dv[8:0], ds[8:0], mx[7:0]};
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom % 8)
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Scoreboard monitor: runs every cycle on the falling edge.
    logic [27:0] exp_q [$];
    logic        hold_prev = 1'b0;
    logic [27:0] hold_val;

    always @(negedge i_clk) begin
        if (!i_rstn) begin
            exp_q.delete();
            hold_prev = 1'b0;
        end else begin
            check("o_ready", {31'd0, o_ready}, {31'd0, !(exp_q.size() == 2 && !i_ready)});
            if (hold_prev) begin
                check("hold_valid", {31'd0, o_valid}, 32'd1);
                check("hold_data", {4'd0, bundle}, {4'd0, hold_val});
            end
            hold_prev = o_valid && !i_ready;
            hold_val  = bundle;
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) check("spurious_valid", {31'd0, o_valid}, 32'd0);
                else                   check("order", {4'd0, bundle}, {4'd0, exp_q.pop_front()});
            end
            if (i_valid && o_ready) exp_q.push_back(model(i_data));
        end
    end

    task automatic single(input string tag, input logic [15:0] pix, input logic [27:0] exp);
        @(posedge i_clk); #1 i_valid = 1'b1; i_data = pix;
        @(posedge i_clk); #1 i_valid = 1'b0;
        @(negedge i_clk); check({tag, "_lat1"}, {31'd0, o_valid}, 32'd0);
        @(negedge i_clk); check({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
        check(tag, {4'd0, bundle}, {4'd0, exp});
    endtask

    logic [15:0] b2b_pix [3] = '{16'h041F, 16'h07E0, 16'hF808};
    logic [27:0] b2b_exp [3] = '{{2'd1, 9'd128, 9'd248, 8'd248},
                                 {2'd2, 9'd0,   9'd252, 8'd252},
                                 {2'd3, 9'd64,  9'd248, 8'd248}};
    logic [15:0] bp_pix  [4] = '{16'h1234, 16'hABCD, 16'h5A5A, 16'hF00F};
    logic        acc;
    logic [27:0] grey_exp;

    initial begin
        fork
            begin
                #500000;
                $display("FAIL timeout: simulation did not finish");
                $fatal(1, "timeout");
            end
        join_none

        #12;
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_bundle", {4'd0, bundle}, 32'd0);
        @(posedge i_clk); #2 i_rstn = 1'b1; i_ready = 1'b1;

        single("red_basic", 16'h001F, {2'd1, 9'd0, 9'd248, 8'd248});

        // Three pixels on consecutive cycles must emerge on consecutive cycles.
        for (int i = 0; i < 5; i++) begin
            @(posedge i_clk); #1;
            if (i < 3) begin i_valid = 1'b1; i_data = b2b_pix[i]; end
            else       i_valid = 1'b0;
            @(negedge i_clk);
            if (i >= 2) begin
                check("b2b_valid", {31'd0, o_valid}, 32'd1);
                check("b2b_data", {4'd0, bundle}, {4'd0, b2b_exp[i-2]});
            end
        end

`ifdef HUE_ACHROMA_EN
        grey_exp = {2'd0, 9'd0, 9'd1, 8'd0};
`else
        grey_exp = {2'd1, 9'd0, 9'd0, 8'd0};
`endif
        single("grey", 16'h0000, grey_exp);
        single("neg_div", 16'h801F, {2'd1, 9'h180, 9'd248, 8'd248});

        // Backpressure: fill both stages, stall three cycles, then release.
        @(posedge i_clk); #1 i_ready = 1'b0; i_valid = 1'b1; i_data = bp_pix[0];
        @(posedge i_clk); #1 i_data = bp_pix[1];
        @(posedge i_clk); #1 i_data = bp_pix[2];
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            check("bp_ready_low", {31'd0, o_ready}, 32'd0);
            check("bp_stall_data", {4'd0, bundle}, {4'd0, model(bp_pix[0])});
            if (k < 2) begin @(posedge i_clk); #1; end
        end
        @(posedge i_clk); #1 i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            check("bp_out_valid", {31'd0, o_valid}, 32'd1);
            check("bp_out_data", {4'd0, bundle}, {4'd0, model(bp_pix[k])});
            @(posedge i_clk); #1;
            if (k == 0) i_data = bp_pix[3];
            if (k == 1) i_valid = 1'b0;
        end

        // Asynchronous reset with two pixels in flight.
        @(posedge i_clk); #1 i_valid = 1'b1; i_data = 16'h07E0;
        @(posedge i_clk); #1 i_data = 16'hF808;
        @(posedge i_clk); #1 i_valid = 1'b0;
        check("pre_rst_valid", {31'd0, o_valid}, 32'd1);
        #2 i_rstn = 1'b0;
        #1;
        check("arst_valid", {31'd0, o_valid}, 32'd0);
        check("arst_bundle", {4'd0, bundle}, 32'd0);
        @(negedge i_clk);
        @(posedge i_clk); #3 i_rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            check("post_rst_idle", {31'd0, o_valid}, 32'd0);
        end
        single("post_rst", 16'h041F, {2'd1, 9'd128, 9'd248, 8'd248});

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 600; c++) begin
            @(negedge i_clk); acc = i_valid && o_ready;
            @(posedge i_clk); #1;
            if (!i_valid || acc) begin
                i_valid = ($urandom % 4) != 0;
                i_data  = pick();
            end
            i_ready = ($urandom % 3) != 0;
        end
        @(negedge i_clk); acc = i_valid && o_ready;
        @(posedge i_clk); #1;
        if (!acc) begin
            // Let the pending pixel be taken before draining.
            i_ready = 1'b1;
            @(posedge i_clk); #1;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge i_clk);
        #1;
        check("drain", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/hue_prep_pipe.md
Name: hue_prep_pipe

Overview:
Parametrised, back-pressurable successor to the single-stage hue front end.
- Unpacks a packed RGB pixel of configurable component widths and normalises each component to a common width.
- Selects the hue sector and produces the signed dividend and the unsigned divisor for the downstream divider, plus the max component (HSV value).
- Two-stage pipeline with valid/ready handshake on both sides; sits between the pixel source and the divider/hue scaler.

Parameters:
R_W, 5, red field width, packed at bits [R_W-1:0]
G_W, 6, green field width, packed at bits [R_W+G_W-1:R_W]
B_W, 5, blue field width, packed at bits [R_W+G_W+B_W-1:R_W+G_W]
W, 8, normalised component width; must be >= max(R_W,G_W,B_W)

Ports:
i_clk  in  1  clock
i_rstn  in  1  asynchronous active-low reset
i_data  in  R_W+G_W+B_W  packed pixel
i_valid  in  1  input pixel valid
o_ready  out  1  block can accept i_data this cycle
o_dividend  out  W+1  signed dividend (two's complement)
o_divisor  out  W+1  unsigned divisor (max-min), MSB always 0
o_value  out  W  max normalised component
o_function  out  2  sector: 1=red max, 2=green max, 3=blue max, 0=none/achromatic
o_valid  out  1  output bundle valid
i_ready  in  1  downstream accepts output this cycle

Behaviour:
- Clock and reset: i_clk is the only clock. i_rstn is asynchronous and active-low.
- Reset: both stage valid flags clear immediately. All outputs go to 0. Reset mid-transfer discards in-flight pixels; no output appears after reset release until new input is accepted.
- Normalisation: zero-pad each component on the LSB side, i.e. comp << (W - C_W). Example: R=31, W=8 gives 248.
- Stage A (accept when i_valid && o_ready):
  - register the normalised R, G, B;
  - register max, min and sector;
  - sector priority on ties is R > G > B: red if R>=G && R>=B; else green if G>=B; else blue.
- Stage B: register the outputs.
  - Red sector: dividend = G-B.
  - Green sector: dividend = B-R.
  - Blue sector: dividend = R-G.
  - Divisor = max-min; o_value = max.
  - Subtraction is done at W+1 bits signed; no overflow is possible.
- Advance rules:
  - advB = !o_valid || i_ready
  - advA = !stageA_valid || advB
  - o_ready = advA (combinational, no skid buffer)
- Latency and throughput: 2 cycles from acceptance to o_valid when there is no stall. Throughput is 1 pixel/cycle with i_ready held high.
- Holding: while o_valid && !i_ready, all outputs hold stable and stage A holds. A new pixel is accepted only if stage A is empty.
- Simultaneous events: output transfer, stage A→B move and new acceptance may all occur in the same cycle; there are no bubbles and no loss.
- Pixel order is preserved; no pixel is duplicated or dropped.
- o_function = 0 only when the optional feature below flags an achromatic pixel; otherwise it is 1..3.

Optional Feature:
Macro HUE_ACHROMA_EN.
- Defined: a pixel with max==min (grey) outputs o_function=0, o_dividend=0, o_divisor=1, o_value=max. This prevents a divide-by-zero downstream.
- Undefined: grey pixels follow the normal sector rule (red wins ties), giving dividend=0 and divisor=0. The downstream block must tolerate a zero divisor.
- Latency and handshake are identical in both builds.

Test Plan:
- Reset then i_data=0x001F, i_ready=1 -> 2 cycles later o_valid=1, function=1, dividend=0, divisor=248, value=248.
- Mixed pixels, back-to-back: 0x041F (R=248,G=128,B=0) -> fn=1, div=128, dvsr=248. 0x07E0 -> fn=2, div=0, dvsr=252. 0xF808 -> fn=3, div=64, dvsr=248. All three on consecutive cycles.
- Grey 0x0000: with HUE_ACHROMA_EN -> fn=0, div=0, dvsr=1. Without it -> fn=1, div=0, dvsr=0.
- Backpressure: stream 4 pixels, hold i_ready=0 for 3 cycles -> outputs stable, o_ready=0 once both stages are full. On release, all 4 emerge in order with no gaps.
- Negative dividend: R=248,G=0,B=128 (0x8000|0x001F) -> fn=1, dividend=-128 (9'h180), divisor=248.
- Assert i_rstn low with 2 pixels in flight -> o_valid drops asynchronously. After release no stale output appears; the next accepted pixel emerges after 2 cycles.
